// File: rtl/cpu_stack_pkg.sv
// Shared constants and request decoding for the CPU hardware stack.
package cpu_stack_pkg;

   localparam int STACK_WIDTH = 32;
   localparam int STACK_DEPTH = 128;

   typedef enum logic [2:0] {
      OP_IDLE,
      OP_CLEAR,
      OP_HOLD,
      OP_PUSH,
      OP_POP,
      OP_XCHG
   } stack_op_e;

   // clear beats hold, hold beats any push/pop request
   function automatic stack_op_e decode_op(input logic clear, input logic hold,
                                           input logic push, input logic pop);
      stack_op_e op;
      if (clear)
         op = OP_CLEAR;
      else if (hold)
         op = OP_HOLD;
      else begin
         case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_XCHG;
            default: op = OP_IDLE;
         endcase
      end
      return op;
   endfunction

endpackage

// File: rtl/cpu_stack_if.sv
// Control-unit <-> stack bundle; master is the control unit, slave is the stack.
interface cpu_stack_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 128
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] d;
   logic             push;
   logic             pop;
   logic             hold;
   logic             clear;
   logic [WIDTH-1:0] q;
   logic [PTR_W:0]   count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   modport master (
      output d, push, pop, hold, clear,
      input  q, count, empty, full, overflow, underflow
   );

   modport slave (
      input  d, push, pop, hold, clear,
      output q, count, empty, full, overflow, underflow
   );

endinterface

// File: rtl/cpu_stack_ram.sv
// Single-port read-first stack storage; its read register is the popped-value output.
module stack_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 128
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     we_i,
   input  logic                     re_i,
   input  logic                     zero_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i)
         mem[addr_i] <= wdata_i;
   end

   // Nonblocking write above keeps a same-edge read returning the old word.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         rdata_q <= '0;
      else if (zero_i)
         rdata_q <= '0;
      else if (re_i)
         rdata_q <= mem[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_stack.sv
// CPU PUSH/POP stack: pointer, sticky error flags, request priority and RAM address mux.
module cpu_stack
   import cpu_stack_pkg::*;
#(
   parameter int WIDTH = STACK_WIDTH,
   parameter int DEPTH = STACK_DEPTH
) (
   input logic        clk,
   input logic        reset,
   cpu_stack_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [PTR_W:0]   sp_q, sp_d, sp_m1;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             empty, full;
   logic             ram_we, ram_re, ram_zero;
   logic [PTR_W-1:0] ram_addr, wr_addr, rd_addr;
   stack_op_e        op;

   assign empty   = (sp_q == '0);
   assign full    = (sp_q == FULL_CNT);
   assign sp_m1   = sp_q - ONE;
   assign wr_addr = sp_q[PTR_W-1:0];
   assign rd_addr = sp_m1[PTR_W-1:0];
   assign op      = decode_op(bus.clear, bus.hold, bus.push, bus.pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Simultaneous push+pop on a non-empty stack swaps the top word in place.
   always_comb begin
      sp_d     = sp_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      ram_we   = 1'b0;
      ram_re   = 1'b0;
      ram_zero = 1'b0;
      ram_addr = rd_addr;
      case (op)
         OP_CLEAR: begin
            sp_d     = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            ram_zero = 1'b1;
         end
         OP_PUSH: begin
            if (full)
               ovf_d = 1'b1;
            else begin
               ram_we   = 1'b1;
               ram_addr = wr_addr;
               sp_d     = sp_q + ONE;
            end
         end
         OP_POP: begin
            if (empty) begin
               unf_d    = 1'b1;
               ram_zero = 1'b1;
            end else begin
               ram_re = 1'b1;
               sp_d   = sp_m1;
            end
         end
         OP_XCHG: begin
            if (empty) begin
               unf_d    = 1'b1;
               ram_zero = 1'b1;
               ram_we   = 1'b1;
               ram_addr = wr_addr;
               sp_d     = sp_q + ONE;
            end else begin
               ram_re = 1'b1;
               ram_we = 1'b1;
            end
         end
         default: ;
      endcase
   end

   stack_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk_i   (clk),
      .rst_n_i (reset),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .zero_i  (ram_zero),
      .addr_i  (ram_addr),
      .wdata_i (bus.d),
      .rdata_o (bus.q)
   );

   assign bus.count     = sp_q;
   assign bus.empty     = empty;
   assign bus.full      = full;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;

endmodule

// File: doc/cpu_stack.md
# cpu_stack

Hardware return/data stack serving the CPU's PUSH and POP opcodes. The control unit asserts `push` or `pop`; this block stores the source-register value on push and returns the top-of-stack value on pop, one cycle later, for the destination-register write. It sits beside the register file in the execute/writeback path and honours pipeline stalls through `hold`.

## Interface
Parameters:
- `WIDTH`, 32, data word width in bits
- `DEPTH`, 128, number of entries; must be a power of two, at least 2
- `PTR_W`, log2(`DEPTH`), derived; never overridden

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge
- `reset`  input  1  asynchronous, active-low reset
- `d`  input  `WIDTH`  value to push (source register contents)
- `push`  input  1  push request from the control unit
- `pop`  input  1  pop request from the control unit
- `hold`  input  1  pipeline stall; push/pop ignored while high
- `clear`  input  1  synchronous stack flush
- `q`  output  `WIDTH`  registered popped value
- `count`  output  `PTR_W`+1  current number of stored entries
- `empty`  output  1  `count` == 0, combinational from `count`
- `full`  output  1  `count` == `DEPTH`, combinational from `count`
- `overflow`  output  1  sticky; push attempted while full
- `underflow`  output  1  sticky; pop attempted while empty

## Operation
- State: stack pointer `sp` (`PTR_W`+1 bits, equals `count`), registered `q`, two sticky flags, `DEPTH`×`WIDTH` storage.
- Priority per edge: `clear` > `hold` > push/pop.
- `clear`: `sp`←0, `q`←0, `overflow`←0, `underflow`←0. Storage is untouched.
- `hold`=1 with no `clear`: no state changes; `q` holds.
- Push only, not full: mem[`sp`]←`d`, `sp`←`sp`+1.
- Push only, full: no write, `sp` unchanged, `overflow`←1.
- Pop only, not empty: `q`←mem[`sp`−1], `sp`←`sp`−1.
- Pop only, empty: `q`←0, `sp` unchanged, `underflow`←1.
- Push and pop together (never issued by the control unit; defined for robustness):
  - Not empty: `q`←old mem[`sp`−1], then mem[`sp`−1]←`d` (read-first). `sp` is unchanged.
  - Empty: `underflow`←1, `q`←0, and the push proceeds as a normal push (`sp`←1).
- Neither push nor pop: `q` keeps its last value. It is not cleared to 0.
- Sticky flags are cleared only by `clear` or reset.
- Arithmetic: `sp` is never wrapped; the full and empty checks prevent modulo behaviour. The RAM address is `sp`[`PTR_W`−1:0] for writes and (`sp`−1)[`PTR_W`−1:0] for reads.

## Timing
- Reset (asynchronous, `reset`=0): `sp`=0, `q`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0. Storage is not reset.
- Pop latency is 1 cycle. With `pop` sampled high at edge N, the value appears on `q` after edge N and is valid for the writeback in cycle N+1.
- Push is visible to a pop issued on the very next cycle (back-to-back push→pop returns `d`).
- `count`, `empty` and `full` reflect the state after the last edge. There is no combinational path from `push`/`pop` to any output.
- Reset asserted mid-operation aborts any in-flight request immediately. The first request after deassertion is accepted at the first rising edge with `reset`=1.

## Structure
- Shared CPU package: `STACK_WIDTH`=32 and `STACK_DEPTH`=128 constants, used by the CPU top to parameterise this block.
- One sub-module, `stack_ram`:
  - single-port, synchronous, read-first RAM
  - `DEPTH`×`WIDTH`, with `we`, `addr`, `wdata`, `rdata`
  - the read register in `stack_ram` is the `q` register
  - infers block RAM
- Top level holds `sp`, the flags, the priority logic and the address mux, using the write address on push and the read address otherwise.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then pop ×3 → `q` = 0x33, 0x22, 0x11 one cycle after each pop; `count` 3→0; `empty`=1 at end.
- `DEPTH`=4 instance: push 5 values → 5th is dropped, `overflow`=1, `full`=1, `count`=4; pop ×4 returns the first four in reverse order.
- Pop on empty → `q`=0, `underflow`=1, `count`=0; a later `clear` → both flags 0.
- Push 0xA5 with `hold`=1 for 3 cycles, then `hold`=0 → no change while held; one push accepted after release, `count`=1.
- Push 0x01, then push+pop together with `d`=0x02 → `q`=0x01, `count`=1; next pop → `q`=0x02.
- Push 2 values, assert `reset` low asynchronously mid-cycle → all outputs at reset values before the next edge; after release, pop → `underflow`=1.
